// File: rtl/decode_cycle.sv
// RV32I decode stage: control decode, 32x32 register file, immediates, ID/EX register.
// Define REGFILE_BYPASS_EN for write-first register reads of the writeback port.
module decode_cycle #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] InstrD,
  input  logic [XLEN-1:0] PCD,
  input  logic [XLEN-1:0] PCPlus4D,
  input  logic            FlushE,
  input  logic            RegWriteW,
  input  logic [4:0]      RdW,
  input  logic [XLEN-1:0] ResultW,
  output logic            RegWriteE,
  output logic            MemWriteE,
  output logic            ALUSrcE,
  output logic            BranchE,
  output logic            JumpE,
  output logic [1:0]      ResultSrcE,
  output logic [2:0]      ALUControlE,
  output logic [XLEN-1:0] RD1E,
  output logic [XLEN-1:0] RD2E,
  output logic [XLEN-1:0] ImmExtE,
  output logic [4:0]      Rs1E,
  output logic [4:0]      Rs2E,
  output logic [4:0]      RdE,
  output logic [XLEN-1:0] PCE,
  output logic [XLEN-1:0] PCPlus4E
);

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_LW = 7'b0000011;
  localparam logic [6:0] OP_SW = 7'b0100011;
  localparam logic [6:0] OP_BR = 7'b1100011;
  localparam logic [6:0] OP_J  = 7'b1101111;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  typedef enum logic [2:0] {
    IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_J
  } imm_e;

  typedef struct packed {
    logic            rw;
    logic            mw;
    logic            as;
    logic            br;
    logic            jp;
    logic [1:0]      rsrc;
    logic [2:0]      alu;
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic [XLEN-1:0] imm;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc4;
  } id_ex_t;

  logic [6:0]      op;
  logic [2:0]      f3;
  logic [4:0]      rs1, rs2;
  logic            alu_ok;
  logic [2:0]      alu_ri;
  imm_e            isel;
  logic [XLEN-1:0] imm;
  logic [XLEN-1:0] rd1, rd2;
  logic            wr_en;
  logic [XLEN-1:0] rf_q [32];
  id_ex_t          ex_d, ex_q;

  assign op    = InstrD[6:0];
  assign f3    = InstrD[14:12];
  assign rs1   = InstrD[19:15];
  assign rs2   = InstrD[24:20];
  assign wr_en = RegWriteW && (RdW != 5'd0);

  // addi never becomes sub; only R-type honours funct7[5]
  always_comb begin
    alu_ok = 1'b1;
    alu_ri = 3'b000;
    case (f3)
      3'b000:  alu_ri = (op == OP_R && InstrD[30]) ? 3'b001 : 3'b000;
      3'b010:  alu_ri = 3'b101;
      3'b110:  alu_ri = 3'b011;
      3'b111:  alu_ri = 3'b010;
      default: alu_ok = 1'b0;
    endcase
  end

  always_comb begin
    ex_d      = '0;
    isel      = IMM_NONE;
    case (op)
      OP_R: if (alu_ok) begin
        ex_d.rw  = 1'b1;
        ex_d.alu = alu_ri;
      end
      OP_I: begin
        isel = IMM_I;
        if (alu_ok) begin
          ex_d.rw  = 1'b1;
          ex_d.as  = 1'b1;
          ex_d.alu = alu_ri;
        end
      end
      OP_LW: begin
        isel      = IMM_I;
        ex_d.rw   = 1'b1;
        ex_d.as   = 1'b1;
        ex_d.rsrc = 2'b01;
      end
      OP_SW: begin
        isel    = IMM_S;
        ex_d.mw = 1'b1;
        ex_d.as = 1'b1;
      end
      OP_BR: begin
        isel     = IMM_B;
        ex_d.br  = 1'b1;
        ex_d.alu = 3'b001;
      end
      OP_J: begin
        isel      = IMM_J;
        ex_d.rw   = 1'b1;
        ex_d.jp   = 1'b1;
        ex_d.rsrc = 2'b10;
      end
      default: ;
    endcase
    ex_d.rd1 = rd1;
    ex_d.rd2 = rd2;
    ex_d.imm = imm;
    ex_d.rs1 = rs1;
    ex_d.rs2 = rs2;
    ex_d.rd  = InstrD[11:7];
    ex_d.pc  = PCD;
    ex_d.pc4 = PCPlus4D;
  end

  always_comb begin
    imm = '0;
    case (isel)
      IMM_I: imm = {{20{InstrD[31]}}, InstrD[31:20]};
      IMM_S: imm = {{20{InstrD[31]}}, InstrD[31:25],
                    InstrD[11:7]};
      IMM_B: imm = {{19{InstrD[31]}}, InstrD[31], InstrD[7],
                    InstrD[30:25], InstrD[11:8], 1'b0};
      IMM_J: imm = {{11{InstrD[31]}}, InstrD[31],
                    InstrD[19:12], InstrD[20],
                    InstrD[30:21], 1'b0};
      default: imm = '0;
    endcase
  end

  always_comb begin
    rd1 = rf_q[rs1];
    rd2 = rf_q[rs2];
    if (BYPASS && wr_en && RdW == rs1) rd1 = ResultW;
    if (BYPASS && wr_en && RdW == rs2) rd2 = ResultW;
    if (rs1 == 5'd0) rd1 = '0;
    if (rs2 == 5'd0) rd2 = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    end else if (wr_en) begin
      rf_q[RdW] <= ResultW;
    end
  end

  // flush squashes the wrong-path instruction into a bubble
  always_ff @(posedge clk) begin
    if (!rst)        ex_q <= '0;
    else if (FlushE) ex_q <= '0;
    else             ex_q <= ex_d;
  end

  assign RegWriteE   = ex_q.rw;
  assign MemWriteE   = ex_q.mw;
  assign ALUSrcE     = ex_q.as;
  assign BranchE     = ex_q.br;
  assign JumpE       = ex_q.jp;
  assign ResultSrcE  = ex_q.rsrc;
  assign ALUControlE = ex_q.alu;
  assign RD1E        = ex_q.rd1;
  assign RD2E        = ex_q.rd2;
  assign ImmExtE     = ex_q.imm;
  assign Rs1E        = ex_q.rs1;
  assign Rs2E        = ex_q.rs2;
  assign RdE         = ex_q.rd;
  assign PCE         = ex_q.pc;
  assign PCPlus4E    = ex_q.pc4;

endmodule

// File: tb/tb_decode_cycle.sv
// Scoreboard bench for decode_cycle: directed instructions, queued expectations.
// Monitor pops one expected ID/EX snapshot per rising edge.
module tb_decode_cycle;

  typedef struct packed {
    logic [9:0]  ctl;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] pc;
    logic [31:0] pc4;
  } out_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] InstrD, PCD, PCPlus4D;
  logic        FlushE, RegWriteW;
  logic [4:0]  RdW;
  logic [31:0] ResultW;
  logic        RegWriteE, MemWriteE, ALUSrcE, BranchE, JumpE;
  logic [1:0]  ResultSrcE;
  logic [2:0]  ALUControlE;
  logic [31:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E;
  logic [4:0]  Rs1E, Rs2E, RdE;

  out_t  eq[$];
  string nq[$];
  int    n_cmp = 0;
  int    n_bad = 0;
  logic [31:0] pc_r = 32'h100;

`ifdef REGFILE_BYPASS_EN
  localparam logic [31:0] BYP_X7 = 32'hA5A5;
`else
  localparam logic [31:0] BYP_X7 = 32'h0;
`endif

  // ctl = {RegWrite,MemWrite,ALUSrc,Branch,Jump,ResultSrc,ALUControl}
  localparam logic [9:0] C_NONE = 10'b0_0_0_0_0_00_000;
  localparam logic [9:0] C_ADD  = 10'b1_0_0_0_0_00_000;
  localparam logic [9:0] C_SUB  = 10'b1_0_0_0_0_00_001;
  localparam logic [9:0] C_OR   = 10'b1_0_0_0_0_00_011;
  localparam logic [9:0] C_ADDI = 10'b1_0_1_0_0_00_000;
  localparam logic [9:0] C_SLTI = 10'b1_0_1_0_0_00_101;
  localparam logic [9:0] C_LW   = 10'b1_0_1_0_0_01_000;
  localparam logic [9:0] C_SW   = 10'b0_1_1_0_0_00_000;
  localparam logic [9:0] C_BEQ  = 10'b0_0_0_1_0_00_001;
  localparam logic [9:0] C_JAL  = 10'b1_0_0_0_1_10_000;

  decode_cycle dut (
    .clk(clk), .rst(rst), .InstrD(InstrD), .PCD(PCD),
    .PCPlus4D(PCPlus4D), .FlushE(FlushE),
    .RegWriteW(RegWriteW), .RdW(RdW), .ResultW(ResultW),
    .RegWriteE(RegWriteE), .MemWriteE(MemWriteE),
    .ALUSrcE(ALUSrcE), .BranchE(BranchE), .JumpE(JumpE),
    .ResultSrcE(ResultSrcE), .ALUControlE(ALUControlE),
    .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE),
    .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
    .PCE(PCE), .PCPlus4E(PCPlus4E)
  );

  always #5 clk = ~clk;

  task automatic step(
    input string       nm,
    input bit          r,
    input logic [31:0] ins,
    input bit          fl,
    input bit          ww,
    input logic [4:0]  wd,
    input logic [31:0] wv,
    input logic [9:0]  ctl,
    input logic [31:0] rd1,
    input logic [31:0] rd2,
    input logic [31:0] imm,
    input logic [4:0]  a1,
    input logic [4:0]  a2,
    input logic [4:0]  ad
  );
    out_t e;
    @(negedge clk);
    rst       = r;
    InstrD    = ins;
    PCD       = pc_r;
    PCPlus4D  = pc_r + 32'd4;
    FlushE    = fl;
    RegWriteW = ww;
    RdW       = wd;
    ResultW   = wv;
    e = '0;
    if (r && !fl) begin
      e.ctl = ctl; e.rd1 = rd1; e.rd2 = rd2; e.imm = imm;
      e.rs1 = a1;  e.rs2 = a2;  e.rd  = ad;
      e.pc  = pc_r; e.pc4 = pc_r + 32'd4;
    end
    eq.push_back(e);
    nq.push_back(nm);
    pc_r = pc_r + 32'd4;
    @(posedge clk);
  endtask

  always @(posedge clk) begin
    #1;
    if (eq.size() > 0) begin
      out_t  e;
      out_t  a;
      string nm;
      e  = eq.pop_front();
      nm = nq.pop_front();
      a  = {RegWriteE, MemWriteE, ALUSrcE, BranchE, JumpE,
            ResultSrcE, ALUControlE, RD1E, RD2E, ImmExtE,
            Rs1E, Rs2E, RdE, PCE, PCPlus4E};
      n_cmp++;
      if (a !== e) begin
        n_bad++;
        $display("FAIL %s: got %h expected %h", nm, a, e);
      end
    end
  end

  initial begin
    rst = 1'b0; InstrD = '0; PCD = '0; PCPlus4D = '0;
    FlushE = 1'b0; RegWriteW = 1'b0; RdW = '0; ResultW = '0;

    step("reset0", 0, 32'hFFB00093, 0, 1, 5, 32'hDEAD,
         C_NONE, 0, 0, 0, 0, 0, 0);
    step("reset1", 0, 32'hFFB00093, 0, 1, 5, 32'hDEAD,
         C_NONE, 0, 0, 0, 0, 0, 0);
    step("x5_after_rst", 1, 32'h000284B3, 0, 0, 0, 0,
         C_ADD, 0, 0, 0, 5, 0, 9);
    step("addi_neg5", 1, 32'hFFB00093, 0, 0, 0, 0,
         C_ADDI, 0, 0, 32'hFFFFFFFB, 0, 27, 1);
    step("wb_x3", 1, 32'h0, 0, 1, 3, 32'h1234,
         C_NONE, 0, 0, 0, 0, 0, 0);
    step("sub_x3x3", 1, 32'h40318233, 0, 1, 0, 32'hFFFF,
         C_SUB, 32'h1234, 32'h1234, 0, 3, 3, 4);
    step("x0_zero", 1, 32'h00000533, 0, 0, 0, 0,
         C_ADD, 0, 0, 0, 0, 0, 10);
    step("same_cyc_x7", 1, 32'h00038433, 0, 1, 7, 32'hA5A5,
         C_ADD, BYP_X7, 0, 0, 7, 0, 8);
    step("x7_next", 1, 32'h00038433, 0, 0, 0, 0,
         C_ADD, 32'hA5A5, 0, 0, 7, 0, 8);
    step("beq_m8", 1, 32'hFE000CE3, 0, 0, 0, 0,
         C_BEQ, 0, 0, 32'hFFFFFFF8, 0, 0, 25);
    step("beq_flush", 1, 32'hFE000CE3, 1, 0, 0, 0,
         C_NONE, 0, 0, 0, 0, 0, 0);
    step("unsupported", 1, 32'h0000007F, 0, 0, 0, 0,
         C_NONE, 0, 0, 0, 0, 0, 0);
    step("lw", 1, 32'h0081A303, 0, 0, 0, 0,
         C_LW, 32'h1234, 0, 32'h8, 3, 8, 6);
    step("sw", 1, 32'hFE30AE23, 0, 0, 0, 0,
         C_SW, 0, 32'h1234, 32'hFFFFFFFC, 1, 3, 28);
    step("jal", 1, 32'h010000EF, 0, 0, 0, 0,
         C_JAL, 0, 0, 32'h10, 0, 16, 1);
    step("or", 1, 32'h0011E133, 0, 0, 0, 0,
         C_OR, 32'h1234, 0, 0, 3, 1, 2);
    step("slti", 1, 32'h0051A113, 0, 0, 0, 0,
         C_SLTI, 32'h1234, 0, 32'h5, 3, 5, 2);
    step("r_bad_f3", 1, 32'h00119133, 0, 0, 0, 0,
         C_NONE, 32'h1234, 0, 0, 3, 1, 2);
    step("addi_f7b5", 1, 32'hC0018113, 0, 0, 0, 0,
         C_ADDI, 32'h1234, 0, 32'hFFFFFC00, 3, 0, 2);
    step("mid_reset", 0, 32'h0, 0, 0, 0, 0,
         C_NONE, 0, 0, 0, 0, 0, 0);
    step("x3_lost", 1, 32'h000184B3, 0, 0, 0, 0,
         C_ADD, 0, 0, 0, 3, 0, 9);

    repeat (3) @(negedge clk);
    n_cmp++;
    if (eq.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending expected 0", eq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
